// File: rtl/perf_snapshot_ctrl.sv
// Performance-counter snapshot controller: sweeps a counter bank into a stream, sharing the bank port with a CSR port.
// Optional clear-after-sample support is enabled by defining PERF_SNAP_CLEAR_EN.
module perf_snapshot_ctrl #(
    parameter int unsigned NR_COUNTERS = 16,
    parameter int unsigned PERIOD_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                start_i,
    input  logic                clear_on_read_i,
    input  logic                csr_req_i,
    input  logic                csr_we_i,
    input  logic [4:0]          csr_addr_i,
    input  logic [63:0]         csr_wdata_i,
    output logic                csr_gnt_o,
    output logic [63:0]         csr_rdata_o,
    output logic [4:0]          ctr_addr_o,
    output logic                ctr_we_o,
    output logic [63:0]         ctr_wdata_o,
    input  logic [63:0]         ctr_rdata_i,
    output logic                snap_valid_o,
    input  logic                snap_ready_i,
    output logic [4:0]          snap_idx_o,
    output logic [63:0]         snap_data_o,
    output logic                snap_last_o,
    output logic                busy_o,
    output logic [7:0]          overrun_cnt_o
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned OVR_W  = 8;

    typedef enum logic [1:0] {IDLE, SAMPLE, OUT} state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q;
    logic [IDX_W-1:0]    idx_q;
    logic [OVR_W-1:0]    overrun_q;
    logic                snap_valid_q, snap_last_q;
    logic [IDX_W-1:0]    snap_idx_q;
    logic [DATA_W-1:0]   snap_data_q;
    logic                timer_trig, trigger, sample_go, beat_done;

    // Periodic timer: fires once every period_i enabled cycles
    assign timer_trig = enable_i && (period_i != '0) && (timer_q == period_i - PERIOD_W'(1));
    assign trigger    = timer_trig | start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (!enable_i || (period_i == '0) || timer_trig) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sample_go = 1'b0;
        beat_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (!csr_req_i) begin
                    sample_go = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                if (snap_ready_i) begin
                    beat_done = 1'b1;
                    state_d   = snap_last_q ? IDLE : SAMPLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sweep index, dropped-trigger counter and the captured beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q        <= '0;
            overrun_q    <= '0;
            snap_valid_q <= 1'b0;
            snap_last_q  <= 1'b0;
            snap_idx_q   <= '0;
            snap_data_q  <= '0;
        end else begin
            if (state_q == IDLE && trigger) begin
                idx_q <= '0;
            end else if (beat_done && !snap_last_q) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (trigger && state_q != IDLE && overrun_q != '1) begin
                overrun_q <= overrun_q + OVR_W'(1);
            end
            if (sample_go) begin
                snap_valid_q <= 1'b1;
                snap_data_q  <= ctr_rdata_i;
                snap_idx_q   <= idx_q;
                snap_last_q  <= (idx_q == IDX_W'(NR_COUNTERS - 1));
            end else if (beat_done) begin
                snap_valid_q <= 1'b0;
            end
        end
    end

    // Bank port mux: CSR always wins; reset forces the write enable and read data low
    always_comb begin
        ctr_addr_o  = idx_q;
        ctr_we_o    = 1'b0;
        ctr_wdata_o = '0;
        csr_rdata_o = '0;
        if (rst_ni) begin
            if (csr_req_i) begin
                ctr_addr_o  = csr_addr_i;
                ctr_we_o    = csr_we_i;
                ctr_wdata_o = csr_wdata_i;
                csr_rdata_o = ctr_rdata_i;
            end else if (sample_go) begin
`ifdef PERF_SNAP_CLEAR_EN
                ctr_we_o = clear_on_read_i;
`endif
            end
        end
    end

`ifndef PERF_SNAP_CLEAR_EN
    logic unused_clear_on_read;
    assign unused_clear_on_read = clear_on_read_i;
`endif

    assign csr_gnt_o     = csr_req_i;
    assign busy_o        = (state_q != IDLE);
    assign overrun_cnt_o = overrun_q;
    assign snap_valid_o  = snap_valid_q;
    assign snap_idx_o    = snap_idx_q;
    assign snap_data_o   = snap_data_q;
    assign snap_last_o   = snap_last_q;

endmodule

// File: tb/tb_perf_snapshot_ctrl.sv
// Self-checking bench for perf_snapshot_ctrl: CSR vector table, directed corner sequences and a randomized
// run checked against a transaction-level model of triggers, sweeps and overruns.
module tb_perf_snapshot_ctrl;

    localparam int unsigned N  = 16;
    localparam int unsigned PW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          enable_i, start_i, clear_on_read_i;
    logic [PW-1:0] period_i;
    logic          csr_req_i, csr_we_i;
    logic [4:0]    csr_addr_i;
    logic [63:0]   csr_wdata_i;
    logic          csr_gnt_o;
    logic [63:0]   csr_rdata_o;
    logic [4:0]    ctr_addr_o;
    logic          ctr_we_o;
    logic [63:0]   ctr_wdata_o, ctr_rdata_i;
    logic          snap_valid_o, snap_ready_i, snap_last_o, busy_o;
    logic [4:0]    snap_idx_o;
    logic [63:0]   snap_data_o;
    logic [7:0]    overrun_cnt_o;

    perf_snapshot_ctrl #(.NR_COUNTERS(N), .PERIOD_W(PW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .period_i(period_i),
        .start_i(start_i), .clear_on_read_i(clear_on_read_i),
        .csr_req_i(csr_req_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_gnt_o(csr_gnt_o), .csr_rdata_o(csr_rdata_o),
        .ctr_addr_o(ctr_addr_o), .ctr_we_o(ctr_we_o), .ctr_wdata_o(ctr_wdata_o),
        .ctr_rdata_i(ctr_rdata_i), .snap_valid_o(snap_valid_o), .snap_ready_i(snap_ready_i),
        .snap_idx_o(snap_idx_o), .snap_data_o(snap_data_o), .snap_last_o(snap_last_o),
        .busy_o(busy_o), .overrun_cnt_o(overrun_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Counter bank: combinational read, old value on simultaneous read/write
    logic [63:0] mem [32];
    assign ctr_rdata_i = mem[ctr_addr_o];
    always @(posedge clk_i) if (ctr_we_o) mem[ctr_addr_o] <= ctr_wdata_o;

    logic [63:0] exp_mem [32];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        req, we;
        logic [4:0]  addr;
        logic [63:0] wdata;
        logic        gnt, cwe;
        logic [63:0] rdata;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] init_val(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i * 'h1111);
    endfunction

    task automatic idle_inputs();
        enable_i = 1'b0; period_i = '0; start_i = 1'b0; clear_on_read_i = 1'b0;
        csr_req_i = 1'b0; csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0;
        snap_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk_i);
        csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
        @(negedge clk_i);
        csr_req_i = 1'b0; csr_we_i = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i); #1;
            if (snap_valid_o) begin ok = 1'b1; break; end
        end
        if (!ok) chk(name, 64'(ok), 64'd1);
    endtask

    task automatic drain(input string name);
        snap_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i); #1;
            if (!busy_o) break;
        end
        chk(name, 64'(busy_o), 64'd0);
    endtask

    // Collect one full sweep with ready held high, checking order, last flag and data
    task automatic collect(input string name, output int beats);
        beats = 0;
        snap_ready_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i); #1;
            if (snap_valid_o) begin
                chk({name, "_idx"}, 64'(snap_idx_o), 64'(beats));
                chk({name, "_last"}, 64'(snap_last_o), 64'(beats == N - 1));
                chk({name, "_data"}, snap_data_o, exp_mem[beats]);
                beats++;
                if (snap_last_o) break;
            end
        end
        chk({name, "_beats"}, 64'(beats), 64'(N));
    endtask

    // Randomized run; model works at transaction level: trigger -> sweep or overrun
    task automatic random_phase(input logic [PW-1:0] per, input int cycles);
        bit       model_busy = 1'b0;
        int       model_ovr = 0, exp_idx = 0, en_run = 0, sweeps = 0;
        bit       prev_hold = 1'b0;
        logic [4:0]  prev_idx = '0;
        logic [63:0] prev_data = '0;
        bit       tt, trig, hs, was_busy;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            period_i     = per;
            enable_i     = ($urandom_range(0, 15) != 0);
            start_i      = ($urandom_range(0, 19) == 0);
            csr_req_i    = ($urandom_range(0, 3) == 0);
            csr_we_i     = 1'b0;
            csr_addr_i   = 5'($urandom_range(0, 31));
            snap_ready_i = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_hold) begin
                chk("rnd_hold_valid", 64'(snap_valid_o), 64'd1);
                chk("rnd_hold_idx", 64'(snap_idx_o), 64'(prev_idx));
                chk("rnd_hold_data", snap_data_o, prev_data);
            end
            chk("rnd_busy", 64'(busy_o), 64'(model_busy));
            chk("rnd_overrun", 64'(overrun_cnt_o), 64'(model_ovr));
            chk("rnd_gnt", 64'(csr_gnt_o), 64'(csr_req_i));
            if (csr_req_i) chk("rnd_rdata", csr_rdata_o, exp_mem[csr_addr_i]);
            else if (!model_busy) chk("rnd_rdata_idle", csr_rdata_o, 64'd0);
            if (snap_valid_o) chk("rnd_valid_in_sweep", 64'(model_busy), 64'd1);
            if (enable_i && per != 0) begin
                tt = ((en_run + 1) % int'(per)) == 0;
                en_run++;
            end else begin
                tt = 1'b0;
                en_run = 0;
            end
            trig = tt || start_i;
            hs   = snap_valid_o && snap_ready_i;
            was_busy = model_busy;
            if (hs) begin
                chk("rnd_idx", 64'(snap_idx_o), 64'(exp_idx));
                chk("rnd_last", 64'(snap_last_o), 64'(exp_idx == N - 1));
                chk("rnd_data", snap_data_o, exp_mem[exp_idx]);
                if (exp_idx == N - 1) begin
                    model_busy = 1'b0;
                    sweeps++;
                end else begin
                    exp_idx++;
                end
            end
            if (trig && was_busy && model_ovr < 255) model_ovr++;
            if (trig && !was_busy) begin
                model_busy = 1'b1;
                exp_idx    = 0;
            end
            prev_hold = snap_valid_o && !snap_ready_i;
            prev_idx  = snap_idx_o;
            prev_data = snap_data_o;
        end
        chk("rnd_sweeps_seen", 64'(sweeps > 0), 64'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int beats;
        int k;
        logic [4:0]  hold_idx;
        logic [63:0] hold_data;
        int seen;

        // Reset state, with a CSR write presented to prove gating
        idle_inputs();
        rst_ni = 1'b0;
        csr_req_i = 1'b1; csr_we_i = 1'b1;
        #1;
        chk("rst_valid", 64'(snap_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ctr_we", 64'(ctr_we_o), 64'd0);
        chk("rst_rdata", csr_rdata_o, 64'd0);
        chk("rst_overrun", 64'(overrun_cnt_o), 64'd0);
        chk("rst_snap", {snap_data_o[58:0], snap_idx_o}, 64'd0);
        do_reset();
        for (int i = 0; i < 32; i++) csr_wr(5'(i), init_val(i));

        // CSR path vectors (engine idle)
        vt[0] = '{1'b1, 1'b0, 5'd2,  64'd0,          1'b1, 1'b0, init_val(2)};
        vt[1] = '{1'b1, 1'b1, 5'd5,  64'hDEAD_0005,  1'b1, 1'b1, init_val(5)};
        vt[2] = '{1'b1, 1'b0, 5'd5,  64'd0,          1'b1, 1'b0, 64'hDEAD_0005};
        vt[3] = '{1'b0, 1'b1, 5'd9,  64'hBEEF,       1'b0, 1'b0, 64'd0};
        vt[4] = '{1'b1, 1'b0, 5'd9,  64'd0,          1'b1, 1'b0, init_val(9)};
        vt[5] = '{1'b1, 1'b0, 5'd31, 64'd0,          1'b1, 1'b0, init_val(31)};
        vt[6] = '{1'b0, 1'b0, 5'd0,  64'd0,          1'b0, 1'b0, 64'd0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            csr_req_i = vt[i].req; csr_we_i = vt[i].we;
            csr_addr_i = vt[i].addr; csr_wdata_i = vt[i].wdata;
            #1;
            chk("vec_gnt", 64'(csr_gnt_o), 64'(vt[i].gnt));
            chk("vec_ctr_we", 64'(ctr_we_o), 64'(vt[i].cwe));
            chk("vec_rdata", csr_rdata_o, vt[i].rdata);
            if (vt[i].req) chk("vec_addr", 64'(ctr_addr_o), 64'(vt[i].addr));
            if (vt[i].req && vt[i].we) chk("vec_wdata", ctr_wdata_o, vt[i].wdata);
        end
        exp_mem[5] = 64'hDEAD_0005;

        // Periodic timer: first sweep 10 cycles after enable, then a full in-order sweep
        do_reset();
        enable_i = 1'b1; period_i = PW'(10); snap_ready_i = 1'b1;
        k = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk_i); #1;
            if (busy_o) begin k = e; break; end
        end
        chk("timer_first_edge", 64'(k), 64'd10);
        enable_i = 1'b0;
        collect("timer", beats);
        drain("timer_done");
        chk("timer_overrun", 64'(overrun_cnt_o), 64'd0);

        // Stalled beat: stable outputs, overrun counting, CSR write to held counter, saturation
        do_reset();
        pulse_start();
        wait_valid("stall_valid");
        chk("stall_idx0", 64'(snap_idx_o), 64'd0);
        chk("stall_data0", snap_data_o, exp_mem[0]);
        hold_idx = snap_idx_o; hold_data = snap_data_o;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk_i);
            start_i = (h == 1);
            csr_req_i = (h == 3); csr_we_i = (h == 3);
            csr_addr_i = 5'd0; csr_wdata_i = 64'hFFFF_0000_1234;
            #1;
            chk("stall_valid_hold", 64'(snap_valid_o), 64'd1);
            chk("stall_idx_hold", 64'(snap_idx_o), 64'(hold_idx));
            chk("stall_data_hold", snap_data_o, hold_data);
        end
        exp_mem[0] = 64'hFFFF_0000_1234;
        @(negedge clk_i);
        start_i = 1'b0; csr_req_i = 1'b0; csr_we_i = 1'b0;
        #1;
        chk("stall_overrun1", 64'(overrun_cnt_o), 64'd1);
        chk("stall_data_after_wr", snap_data_o, hold_data);
        for (int p = 0; p < 299; p++) pulse_start();
        #1;
        chk("overrun_sat", 64'(overrun_cnt_o), 64'd255);
        drain("stall_drain");
        chk("overrun_sat_after", 64'(overrun_cnt_o), 64'd255);

        // CSR holds the bank for 3 cycles while the engine sits in SAMPLE
        do_reset();
        snap_ready_i = 1'b0;
        pulse_start();
        for (int s = 0; s < 3; s++) begin
            csr_req_i = 1'b1; csr_addr_i = 5'd7;
            #1;
            chk("csrstall_gnt", 64'(csr_gnt_o), 64'd1);
            chk("csrstall_busy", 64'(busy_o), 64'd1);
            chk("csrstall_valid", 64'(snap_valid_o), 64'd0);
            chk("csrstall_rdata", csr_rdata_o, exp_mem[7]);
            chk("csrstall_addr", 64'(ctr_addr_o), 64'd7);
            @(negedge clk_i);
        end
        csr_req_i = 1'b0;
        #1;
        chk("csrstall_still", 64'(snap_valid_o), 64'd0);
        @(posedge clk_i); #1;
        chk("csrstall_resume_valid", 64'(snap_valid_o), 64'd1);
        chk("csrstall_resume_idx", 64'(snap_idx_o), 64'd0);
        chk("csrstall_resume_data", snap_data_o, exp_mem[0]);
        drain("csrstall_drain");

        // Reset during OUT discards the sweep
        do_reset();
        pulse_start();
        wait_valid("rstout_valid");
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("rstout_valid_async", 64'(snap_valid_o), 64'd0);
        chk("rstout_busy_async", 64'(busy_o), 64'd0);
        chk("rstout_last_async", 64'(snap_last_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1; snap_ready_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i); #1;
            if (snap_valid_o || busy_o) seen++;
        end
        chk("rstout_no_beats", 64'(seen), 64'd0);
        snap_ready_i = 1'b0;
        pulse_start();
        wait_valid("rstout_retrigger");
        chk("rstout_new_idx", 64'(snap_idx_o), 64'd0);
        drain("rstout_drain");

        random_phase(PW'(7), 700);
        random_phase(PW'(0), 500);
        random_phase(PW'(23), 700);

        // Clear-on-read: sample returns the pre-clear value
        do_reset();
        csr_wr(5'd3, 64'h55);
        clear_on_read_i = 1'b1;
        pulse_start();
        collect("clr", beats);
        drain("clr_drain");
        clear_on_read_i = 1'b0;
        @(negedge clk_i);
        csr_req_i = 1'b1; csr_addr_i = 5'd3;
        #1;
`ifdef PERF_SNAP_CLEAR_EN
        chk("clr_readback", csr_rdata_o, 64'd0);
`else
        chk("clr_readback", csr_rdata_o, 64'h55);
`endif
        @(negedge clk_i);
        csr_req_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/perf_snapshot_ctrl.md
PERF_SNAPSHOT_CTRL -- requirements
Module: perf_snapshot_ctrl

Interface
REQ-001 SHALL have parameter NR_COUNTERS, default 16, number of counters swept, addresses 0..NR_COUNTERS-1, range 1..32.
REQ-002 SHALL have parameter PERIOD_W, default 16, width of the sample-period field.
REQ-003 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset; asynchronous, active-low.
- enable_i, in, 1, enables the periodic timer.
- period_i, in, PERIOD_W, sample period in cycles; 0 disables the timer.
- start_i, in, 1, software sweep trigger pulse.
- clear_on_read_i, in, 1, zero each counter after it is sampled.
- csr_req_i, in, 1, CSR access request.
- csr_we_i, in, 1, CSR write.
- csr_addr_i, in, 5, CSR counter address.
- csr_wdata_i, in, 64, CSR write data.
- csr_gnt_o, out, 1, CSR grant.
- csr_rdata_o, out, 64, CSR read data.
- ctr_addr_o, out, 5, counter-bank address.
- ctr_we_o, out, 1, counter-bank write enable.
- ctr_wdata_o, out, 64, counter-bank write data.
- ctr_rdata_i, in, 64, counter-bank read data; combinational from ctr_addr_o; the bank returns the old value on read-and-write in the same cycle.
- snap_valid_o, out, 1, snapshot stream valid.
- snap_ready_i, in, 1, snapshot stream ready.
- snap_idx_o, out, 5, counter index of the current beat.
- snap_data_o, out, 64, sampled counter value.
- snap_last_o, out, 1, final beat of a sweep.
- busy_o, out, 1, sweep in progress.
- overrun_cnt_o, out, 8, count of dropped triggers.

Function
REQ-004 The block SHALL arbitrate the counter-bank port between the CSR port and the sweep engine.
REQ-005 The CSR port SHALL have absolute priority: csr_gnt_o = csr_req_i every cycle.
REQ-006 On a CSR grant, the block SHALL drive ctr_addr_o=csr_addr_i, ctr_we_o=csr_we_i, ctr_wdata_o=csr_wdata_i, and csr_rdata_o=ctr_rdata_i in the same cycle (zero latency).
REQ-007 When the CSR port is not granted and the engine is not in SAMPLE, the block SHALL drive ctr_we_o=0 and csr_rdata_o=0.
REQ-008 Timer: timer_q SHALL be cleared whenever enable_i=0 or period_i=0.
REQ-009 Otherwise, if timer_q==period_i-1 the block SHALL assert the trigger and clear timer_q, else increment timer_q; the first trigger occurs period_i cycles after enable.
REQ-010 trigger SHALL be the timer trigger OR start_i.
REQ-011 FSM states SHALL be IDLE, SAMPLE, and OUT.
- IDLE: on trigger, set idx_q=0 and go to SAMPLE.
- SAMPLE: if csr_req_i=1, stall in place. Else drive ctr_addr_o=idx_q, capture ctr_rdata_i into snap_data_o, set snap_idx_o=idx_q and snap_last_o=(idx_q==NR_COUNTERS-1), and go to OUT.
- OUT: assert snap_valid_o; on snap_ready_i, go to IDLE if last, else increment idx_q and go to SAMPLE.
REQ-012 busy_o SHALL be 1 in SAMPLE and OUT.
REQ-013 snap_valid_o, snap_idx_o, snap_data_o, and snap_last_o SHALL be registered and SHALL stay stable while valid is high and ready is low.
REQ-014 A trigger arriving while busy_o=1 SHALL be dropped and SHALL increment overrun_cnt_o, saturating at 255.
REQ-015 A trigger arriving in the same cycle that OUT completes the last beat SHALL also count as an overrun; no back-to-back restart.
REQ-016 A CSR write to the counter currently held in OUT SHALL NOT alter the captured snap_data_o.
REQ-017 enable_i deassertion mid-sweep SHALL NOT abort the sweep.
REQ-018 Each sweep SHALL produce exactly NR_COUNTERS beats, with idx 0..NR_COUNTERS-1 in order.

Reset
REQ-019 On rst_ni low, the block SHALL force the FSM to IDLE and timer_q, idx_q, and overrun_cnt_o to 0.
REQ-020 Under reset, all snap_* outputs, busy_o, ctr_we_o, and csr_rdata_o SHALL be 0, asynchronously.
REQ-021 Reset mid-sweep SHALL discard the sweep; no beat SHALL be emitted after release until a new trigger.

Configuration
REQ-022 Macro PERF_SNAP_CLEAR_EN defined: in SAMPLE (not stalled) with clear_on_read_i=1, the block SHALL also drive ctr_we_o=1 and ctr_wdata_o=0, so the sampled value is the pre-clear value.
REQ-023 Macro PERF_SNAP_CLEAR_EN undefined: the engine SHALL never write, and clear_on_read_i SHALL be ignored.

Verification
REQ-024 The bench SHALL cover these scenarios:
- enable_i=1, period_i=10, snap_ready_i=1, NR_COUNTERS=16 -> first SAMPLE 10 cycles after enable; 16 beats, idx 0..15; snap_last_o only on idx 15.
- Sweep in OUT with snap_ready_i held 0 for 5 cycles -> snap_data_o/snap_idx_o stable; start_i pulse -> overrun_cnt_o=1.
- csr_req_i held 3 cycles during SAMPLE -> csr_gnt_o=1 each cycle; engine resumes on cycle 4 with the same idx.
- With PERF_SNAP_CLEAR_EN, clear_on_read_i=1, counter 3=0x55 -> beat idx 3 data=0x55; a subsequent CSR read of addr 3 returns 0.
- 300 start_i pulses during a stalled sweep -> overrun_cnt_o saturates at 255.
- rst_ni pulsed low during OUT -> snap_valid_o=0 immediately; no beats until the next trigger.
